// File: rtl/twiddle_addr_gen_if.sv
// Address stream from the twiddle sequencer to the butterfly scheduler.
// Carries the ROM address plus its stage/butterfly tags under valid/ready.
interface twiddle_addr_gen_if #(
  parameter int ADDR_WIDTH = 16
);
  logic [ADDR_WIDTH-1:0] addr;
  logic                  addr_valid;
  logic                  addr_ready;
  logic [3:0]            stage;
  logic [14:0]           bfly;
  logic                  last;

  modport master (
    output addr,
    output addr_valid,
    output stage,
    output bfly,
    output last,
    input  addr_ready
  );

  modport slave (
    input  addr,
    input  addr_valid,
    input  stage,
    input  bfly,
    input  last,
    output addr_ready
  );
endinterface

// File: rtl/twiddle_addr_gen.sv
// Twiddle ROM address sequencer for a radix-2 DIT FFT of 2^L points.
// Emits one {base, quadrant} address per butterfly, stage by stage.
module twiddle_addr_gen #(
  parameter int MAX_FFT_LENGTH_LOG2 = 12,
  parameter int ADDR_WIDTH          = 16
) (
  input  logic               clk_i,
  input  logic               reset_n_i,
  input  logic               start_i,
  input  logic [3:0]         fft_len_log2_i,
  input  logic               abort_i,
  twiddle_addr_gen_if.master tw,
  output logic               busy_o,
  output logic               done_o,
  output logic               err_o
);

  localparam int MAXL = MAX_FFT_LENGTH_LOG2;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

  state_t                state_q, state_d;
  logic [3:0]            len_q, len_d;
  logic [3:0]            s_q, s_d;
  logic [14:0]           b_q, b_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic                  valid_q, valid_d;
  logic                  last_q, last_d;
  logic                  busy_q, busy_d;
  logic                  done_q, done_d;
  logic                  err_q, err_d;

  logic                  hs;
  logic                  len_ok;
  logic [14:0]           half_m1;
  logic [3:0]            s_inc;
  logic [14:0]           b_inc;

  // g = (b mod 2^s) << (MAX-1-s) folds the k and grid shifts into one.
  function automatic logic [ADDR_WIDTH-1:0] calc_addr(
    input logic [3:0]  s,
    input logic [14:0] b
  );
    logic [31:0]           m;
    logic [MAXL-1:0]       g;
    logic [ADDR_WIDTH-1:0] a;
    m = {17'd0, b} & ((32'd1 << s) - 32'd1);
    g = MAXL'(m << (32'(MAXL - 1) - 32'(s)));
    a = '0;
    a[MAXL-1:0] = {g[MAXL-3:0], g[MAXL-1:MAXL-2]};
    return a;
  endfunction

  always_comb begin
    hs      = valid_q & tw.addr_ready;
    len_ok  = (fft_len_log2_i != 4'd0) &&
              (32'(fft_len_log2_i) <= 32'(MAXL));
    half_m1 = (15'd1 << (len_q - 4'd1)) - 15'd1;
    if (b_q == half_m1) begin
      b_inc = 15'd0;
      s_inc = s_q + 4'd1;
    end else begin
      b_inc = b_q + 15'd1;
      s_inc = s_q;
    end
  end

  always_comb begin
    state_d = state_q;
    len_d   = len_q;
    s_d     = s_q;
    b_d     = b_q;
    addr_d  = addr_q;
    valid_d = valid_q;
    last_d  = last_q;
    err_d   = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (start_i && !abort_i) begin
          if (len_ok) begin
            state_d = RUN;
            len_d   = fft_len_log2_i;
            s_d     = 4'd0;
            b_d     = 15'd0;
            addr_d  = '0;
            valid_d = 1'b1;
            last_d  = (fft_len_log2_i == 4'd1);
          end else begin
            err_d = 1'b1;
          end
        end
      end
      RUN: begin
        if (abort_i || (hs && last_q)) begin
          state_d = abort_i ? IDLE : DONE;
          s_d     = 4'd0;
          b_d     = 15'd0;
          addr_d  = '0;
          valid_d = 1'b0;
          last_d  = 1'b0;
        end else if (hs) begin
          s_d    = s_inc;
          b_d    = b_inc;
          addr_d = calc_addr(s_inc, b_inc);
          last_d = (s_inc == len_q - 4'd1) &&
                   (b_inc == half_m1);
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
        valid_d = 1'b0;
        last_d  = 1'b0;
      end
    endcase

    // An abort on the final handshake lands in IDLE, so done stays low.
    busy_d = (state_d == RUN);
    done_d = (state_d == DONE);
  end

  always_ff @(posedge clk_i) begin
    if (!reset_n_i) begin
      state_q <= IDLE;
      len_q   <= 4'd0;
      s_q     <= 4'd0;
      b_q     <= 15'd0;
      addr_q  <= '0;
      valid_q <= 1'b0;
      last_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      len_q   <= len_d;
      s_q     <= s_d;
      b_q     <= b_d;
      addr_q  <= addr_d;
      valid_q <= valid_d;
      last_q  <= last_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      err_q   <= err_d;
    end
  end

  assign tw.addr       = addr_q;
  assign tw.addr_valid = valid_q;
  assign tw.stage      = s_q;
  assign tw.bfly       = b_q;
  assign tw.last       = last_q;
  assign busy_o        = busy_q;
  assign done_o        = done_q;
  assign err_o         = err_q;

endmodule

// File: tb/tb_twiddle_addr_gen.sv
// Self-checking bench for twiddle_addr_gen against a queue-based model.
// Random back-pressure, abort, reset and illegal-length scenarios.
module tb_twiddle_addr_gen;

  typedef struct packed {
    logic [15:0] a;
    logic [3:0]  s;
    logic [14:0] b;
    logic        l;
  } item_t;

  logic       clk = 1'b0;
  logic       reset_n;
  logic       start;
  logic [3:0] len;
  logic       abort;
  logic       busy, done, err;

  twiddle_addr_gen_if ifc ();

  twiddle_addr_gen dut (
    .clk_i         (clk),
    .reset_n_i     (reset_n),
    .start_i       (start),
    .fft_len_log2_i(len),
    .abort_i       (abort),
    .tw            (ifc),
    .busy_o        (busy),
    .done_o        (done),
    .err_o         (err)
  );

  always #5 clk = ~clk;

  int          tests = 0;
  int          fails = 0;
  item_t       q[$];
  int          hs_cnt = 0;
  int          vcnt = 0;
  int          cyc = 0;
  int          last_cyc = -10;
  int          done_cnt = 0;
  int          err_cnt = 0;
  bit          rmode = 1'b0;
  logic [15:0] cap [24576];
  logic [15:0] exp3 [12];

  task automatic chk(input string name,
                     input logic [63:0] got,
                     input logic [63:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s got=%0h exp=%0h", name, got, exp);
    end
  endtask

  // Reference: exponent k from the DIT rule, then rescale and split.
  function automatic item_t mk(int lg, int s, int b);
    item_t it;
    int k, g;
    k = (b % (1 << s)) << (lg - 1 - s);
    g = k << (12 - lg);
    it.a = 16'(((g % 1024) << 2) | (g / 1024));
    it.s = 4'(s);
    it.b = 15'(b);
    it.l = (s == lg - 1) && (b == (1 << (lg - 1)) - 1);
    return it;
  endfunction

  task automatic build(input int lg);
    q.delete();
    for (int s = 0; s < lg; s++)
      for (int b = 0; b < (1 << (lg - 1)); b++)
        q.push_back(mk(lg, s, b));
  endtask

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  initial begin
    ifc.addr_ready = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      ifc.addr_ready = rmode ? 1'($urandom_range(0, 1)) : 1'b1;
    end
  end

  // Compare process: every valid cycle must show the model's queue head.
  initial forever begin
    item_t e;
    @(negedge clk);
    if (ifc.addr_valid === 1'b1) begin
      if (q.size() == 0) begin
        chk("unexpected_valid", 64'(ifc.addr), 64'hDEAD);
      end else begin
        e = q[0];
        vcnt++;
        chk("stream", {ifc.addr, ifc.stage, ifc.bfly,
                       ifc.last, busy},
            {e, 1'b1});
        if (ifc.addr_ready === 1'b1) begin
          if (hs_cnt < 24576) cap[hs_cnt] = ifc.addr;
          if (e.l) last_cyc = cyc;
          void'(q.pop_front());
          hs_cnt++;
        end
      end
    end
    if (done === 1'b1) begin
      done_cnt++;
      chk("done_timing", 64'(cyc), 64'(last_cyc + 1));
    end
    if (err === 1'b1) err_cnt++;
  end

  task automatic run(input int lg, input bit rm, input bit mid);
    int d0, e0, t;
    build(lg);
    rmode  = rm;
    hs_cnt = 0;
    vcnt   = 0;
    d0     = done_cnt;
    e0     = err_cnt;
    @(posedge clk); #1;
    len = 4'(lg);
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    t = 0;
    while (!(done_cnt != d0 && q.size() == 0) && t < 60000) begin
      @(posedge clk); #1;
      start = 1'b0;
      if (mid && hs_cnt == 3 && t < 8) begin
        len = 4'd5;
        start = 1'b1;
      end
      t++;
    end
    start = 1'b0;
    if (t >= 60000)
      chk("run_timeout", 64'(t), 64'(0));
    repeat (3) @(negedge clk);
    chk("done_once", 64'(done_cnt), 64'(d0 + 1));
    chk("hs_total", 64'(hs_cnt), 64'(lg << (lg - 1)));
    chk("no_err", 64'(err_cnt), 64'(e0));
    if (!rm)
      chk("throughput", 64'(vcnt), 64'(lg << (lg - 1)));
  endtask

  task automatic err_test(input logic [3:0] bad);
    rmode = 1'b0;
    @(posedge clk); #1;
    len = bad;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    @(negedge clk);
    chk("err_pulse", {err, busy, ifc.addr_valid}, 3'b100);
    @(negedge clk);
    chk("err_clear", {err, busy, ifc.addr_valid}, 3'b000);
    repeat (3) @(negedge clk);
    chk("err_idle", {busy, ifc.addr_valid}, 2'b00);
  endtask

  task automatic interrupt(input bit use_rst);
    int d0, t;
    build(4);
    rmode  = 1'b0;
    hs_cnt = 0;
    d0     = done_cnt;
    @(posedge clk); #1;
    len = 4'd4;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    t = 0;
    while (hs_cnt != (use_rst ? 6 : 4) && t < 200) begin
      @(posedge clk); #1;
      t++;
    end
    if (t >= 200) chk("intr_timeout", 64'(t), 64'(0));
    if (use_rst) reset_n = 1'b0;
    else abort = 1'b1;
    @(posedge clk); #1;
    reset_n = 1'b1;
    abort = 1'b0;
    q.delete();
    @(negedge clk);
    if (use_rst)
      chk("rst_outputs", {ifc.addr, ifc.addr_valid, ifc.stage,
                          ifc.bfly, ifc.last, busy, done, err},
          64'd0);
    else
      chk("abort_drop", {ifc.addr_valid, busy, done}, 3'b000);
    repeat (4) @(negedge clk);
    chk("intr_no_done", 64'(done_cnt), 64'(d0));
  endtask

  initial begin
    exp3 = '{16'h0000, 16'h0000, 16'h0000, 16'h0000,
             16'h0000, 16'h0001, 16'h0000, 16'h0001,
             16'h0000, 16'h0800, 16'h0001, 16'h0801};
    reset_n = 1'b0;
    start   = 1'b0;
    len     = 4'd0;
    abort   = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("reset_state", {ifc.addr, ifc.addr_valid, ifc.stage,
                        ifc.bfly, ifc.last, busy, done, err},
        64'd0);
    @(posedge clk); #1;
    reset_n = 1'b1;

    run(3, 1'b0, 1'b0);
    for (int i = 0; i < 12; i++)
      chk($sformatf("l3_addr%0d", i), 64'(cap[i]), 64'(exp3[i]));
    run(1, 1'b0, 1'b0);
    chk("l1_addr", 64'(cap[0]), 64'd0);
    run(3, 1'b1, 1'b0);
    for (int i = 0; i < 12; i++)
      chk($sformatf("l3bp_addr%0d", i), 64'(cap[i]), 64'(exp3[i]));
    run(4, 1'b0, 1'b1);
    err_test(4'd0);
    err_test(4'd13);
    interrupt(1'b0);
    run(4, 1'b0, 1'b0);
    interrupt(1'b1);
    run(4, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++)
      run(int'($urandom_range(1, 7)), 1'b1, 1'b0);
    run(12, 1'b0, 1'b0);
    chk("l12_s11_b1", 64'(cap[11 * 2048 + 1]), 64'h4);
    chk("l12_s11_b1024", 64'(cap[11 * 2048 + 1024]), 64'h1);
    chk("l12_s11_b1025", 64'(cap[11 * 2048 + 1025]), 64'h5);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
